// File: rtl/wb_slave_mem.sv
// ---------------------------------------------------------------------------
// wb_slave_mem
//   Wishbone classic responder backed by a small word-addressed register-file
//   memory. A single-cycle STB_I & CYC_I seen while idle is latched in full
//   (address, data, direction, byte lanes). The DAT_I bus may therefore change
//   freely afterwards. The request is answered with a one-cycle ACK_O,
//   WAIT_CYCLES + 1 cycles after the capture edge. Requests that arrive while a
//   transaction is in flight, including the ACK_O cycle, are dropped, not
//   queued.
//
// Ports
//   clk_i   in   1             clock, rising edge
//   rst_ni  in   1             asynchronous active-low reset (clears memory too)
//   ADR_I   in   ADDR_WIDTH    byte address; bits [1:0] ignored
//   DAT_I   in   DATA_WIDTH    write data
//   DAT_O   out  DATA_WIDTH    read data, valid while ACK_O=1, held afterwards
//   WE_I    in   1             1 = write, 0 = read
//   SEL_I   in   DATA_WIDTH/8  byte-lane enables for writes
//   STB_I   in   1             strobe
//   CYC_I   in   1             bus cycle
//   ACK_O   out  1             one-cycle acknowledge
// ---------------------------------------------------------------------------
module wb_slave_mem #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [ADDR_WIDTH-1:0]   ADR_I,
  input  logic [DATA_WIDTH-1:0]   DAT_I,
  output logic [DATA_WIDTH-1:0]   DAT_O,
  input  logic                    WE_I,
  input  logic [DATA_WIDTH/8-1:0] SEL_I,
  input  logic                    STB_I,
  input  logic                    CYC_I,
  output logic                    ACK_O
);

  localparam int IDXW  = $clog2(DEPTH);
  localparam int LANES = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK
  } state_t;

  state_t                  state_reg;
  logic [3:0]              cnt_reg;
  logic [IDXW-1:0]         idx_reg;
  logic                    in_range_reg;
  logic                    we_reg;
  logic [DATA_WIDTH-1:0]   dat_reg;
  logic [LANES-1:0]        sel_reg;
  logic                    ack_reg;
  logic [DATA_WIDTH-1:0]   rdata_reg;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    request;
  logic                    addr_in_range;
  logic [IDXW-1:0]         addr_index;
  logic                    finish;
  logic [LANES-1:0]        lane_we;
  logic                    unused_addr_bits;

  assign request       = STB_I & CYC_I;
  // Anything at or above DEPTH*4 bytes is out of range: all address bits
  // above the word index must be zero.
  assign addr_in_range = ((ADR_I >> (IDXW + 2)) == '0);
  assign addr_index    = ADR_I[IDXW+1:2];
  // Byte offset within a word carries no meaning (no misalignment errors).
  assign unused_addr_bits = ^ADR_I[1:0];

  // The counter is loaded with WAIT_CYCLES at capture and the WAIT state is
  // always visited at least once, so the edge that leaves WAIT (counter at 0)
  // is capture + WAIT_CYCLES + 1. That edge raises ACK_O and commits the
  // access, so data and acknowledge appear together.
  assign finish = (state_reg == S_WAIT) && (cnt_reg == 4'd0);

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane_we
    assign lane_we[gi] = finish & we_reg & in_range_reg & sel_reg[gi];
  end

  // Control path: capture, wait countdown, registered acknowledge and read data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg    <= S_IDLE;
      cnt_reg      <= 4'd0;
      idx_reg      <= '0;
      in_range_reg <= 1'b0;
      we_reg       <= 1'b0;
      dat_reg      <= '0;
      sel_reg      <= '0;
      ack_reg      <= 1'b0;
      rdata_reg    <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          ack_reg <= 1'b0;
          if (request) begin
            idx_reg      <= addr_index;
            in_range_reg <= addr_in_range;
            we_reg       <= WE_I;
            dat_reg      <= DAT_I;
            sel_reg      <= SEL_I;
            cnt_reg      <= 4'(WAIT_CYCLES);
            state_reg    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_reg == 4'd0) begin
            state_reg <= S_ACK;
            ack_reg   <= 1'b1;
            if (!we_reg) begin
              rdata_reg <= in_range_reg ? mem[idx_reg] : '0;
            end
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        S_ACK: begin
          // ACK_O is high during this state; a request seen here is dropped.
          ack_reg   <= 1'b0;
          state_reg <= S_IDLE;
        end
        default: begin
          ack_reg   <= 1'b0;
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  // Storage: cleared by reset, byte-lane writes committed on the ACK edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int w = 0; w < DEPTH; w++) begin
        mem[w] <= '0;
      end
    end else begin
      for (int b = 0; b < LANES; b++) begin
        if (lane_we[b]) begin
          mem[idx_reg][b*8 +: 8] <= dat_reg[b*8 +: 8];
        end
      end
    end
  end

  assign ACK_O = ack_reg;
  assign DAT_O = rdata_reg;

endmodule

// File: tb/tb_wb_slave_mem.sv
// ---------------------------------------------------------------------------
// tb_wb_slave_mem
//   Drives three copies of wb_slave_mem (WAIT_CYCLES = 0, 1, 3) from one shared
//   bus and checks each against the expected latency, acknowledge count and
//   read data. Expected data comes from a vector table for directed cases and
//   from a byte-lane memory model for the random phase.
// ---------------------------------------------------------------------------
module tb_wb_slave_mem;

  localparam int NDUT   = 3;
  localparam int WINDOW = 14;

  logic        clk;
  logic        rst_n;
  logic [31:0] adr;
  logic [31:0] dat;
  logic        we;
  logic [3:0]  sel;
  logic        stb;
  logic        cyc;
  logic        ack_w  [NDUT];
  logic [31:0] dato_w [NDUT];

  for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
    localparam int WC = (gi == 0) ? 0 : ((gi == 1) ? 1 : 3);
    wb_slave_mem #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .DEPTH      (64),
      .WAIT_CYCLES(WC)
    ) u_dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .ADR_I (adr),
      .DAT_I (dat),
      .DAT_O (dato_w[gi]),
      .WE_I  (we),
      .SEL_I (sel),
      .STB_I (stb),
      .CYC_I (cyc),
      .ACK_O (ack_w[gi])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int txn_id = 0;

  int          got_cnt  [NDUT];
  int          got_cyc  [NDUT];
  logic [31:0] got_dat  [NDUT];
  logic        dbl      [NDUT];
  logic        prev_ack [NDUT];

  logic [31:0] model_mem [64];

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [16];

  function automatic int wait_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
  endfunction

  // Requests are captured when idle; a held strobe is recaptured one cycle
  // after ACK_O falls, so captures repeat every WAIT_CYCLES + 3 edges.
  function automatic int exp_acks(input int w, input int hold);
    int n;
    n = 0;
    for (int e = 0; e < hold; e += w + 3) n++;
    return n;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (a < 32'd256) return model_mem[a / 4];
    return 32'h0;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (a < 32'd256) begin
      for (int b = 0; b < 4; b++) begin
        if (s[b]) model_mem[a / 4][8*b +: 8] = d[8*b +: 8];
      end
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 64; i++) model_mem[i] = 32'h0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One bus transaction: strobe held for 'hold' edges, then the bus is
  // scrambled and CYC dropped while all copies are watched for WINDOW edges.
  task automatic do_txn(input logic t_we, input logic [31:0] t_adr, input logic [31:0] t_dat,
                        input logic [3:0] t_sel, input int hold);
    @(negedge clk);
    we = t_we; adr = t_adr; dat = t_dat; sel = t_sel; stb = 1'b1; cyc = 1'b1;
    for (int k = 0; k < NDUT; k++) begin
      got_cnt[k] = 0; got_cyc[k] = -1; got_dat[k] = 32'h0; dbl[k] = 1'b0; prev_ack[k] = 1'b0;
    end
    for (int c = 0; c < WINDOW; c++) begin
      @(posedge clk); #1;
      for (int k = 0; k < NDUT; k++) begin
        if (ack_w[k]) begin
          if (prev_ack[k]) dbl[k] = 1'b1;
          if (got_cnt[k] == 0) begin
            got_cyc[k] = c;
            got_dat[k] = dato_w[k];
          end
          got_cnt[k]++;
        end
        prev_ack[k] = ack_w[k];
      end
      if (c == hold - 1) begin
        stb = 1'b0; cyc = 1'b0;
        we = 1'($urandom); adr = $urandom; dat = $urandom; sel = 4'($urandom);
      end
    end
  endtask

  task automatic check_txn(input string tag, input logic t_we, input logic [31:0] exp_rd,
                           input int hold, input logic [NDUT-1:0] mask);
    txn_id++;
    $display("txn %0d %s we=%0b acks=%0d/%0d/%0d at=%0d/%0d/%0d rd=%h/%h/%h", txn_id, tag, t_we,
             got_cnt[0], got_cnt[1], got_cnt[2], got_cyc[0], got_cyc[1], got_cyc[2],
             got_dat[0], got_dat[1], got_dat[2]);
    for (int k = 0; k < NDUT; k++) begin
      if (mask[k]) begin
        chk($sformatf("%s dut%0d ack_count", tag, k), got_cnt[k], exp_acks(wait_of(k), hold));
        chk($sformatf("%s dut%0d ack_latency", tag, k), got_cyc[k], wait_of(k) + 1);
        chk($sformatf("%s dut%0d ack_double", tag, k), {31'h0, dbl[k]}, 32'h0);
        if (!t_we) begin
          chk($sformatf("%s dut%0d rdata", tag, k), got_dat[k], exp_rd);
          chk($sformatf("%s dut%0d rdata_hold", tag, k), dato_w[k], exp_rd);
        end
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  initial begin
    logic        r_we;
    logic [31:0] r_adr;
    logic [31:0] r_dat;
    logic [3:0]  r_sel;
    logic [31:0] r_exp;
    int          cnt1;
    int          cyc1;
    int          quiet;

    rst_n = 1'b1; adr = 32'h0; dat = 32'h0; we = 1'b0; sel = 4'h0; stb = 1'b0; cyc = 1'b0;
    model_clear();

    vecs[0]  = '{1'b1, 32'h0000_0008, 32'h1234_5678, 4'hF, 32'h0};
    vecs[1]  = '{1'b0, 32'h0000_0008, 32'h0,         4'h0, 32'h1234_5678};
    vecs[2]  = '{1'b1, 32'h0000_000C, 32'hAABB_CCDD, 4'hF, 32'h0};
    vecs[3]  = '{1'b1, 32'h0000_000C, 32'h1122_3344, 4'h5, 32'h0};
    vecs[4]  = '{1'b0, 32'h0000_000C, 32'h0,         4'hF, 32'hAA22_CC44};
    vecs[5]  = '{1'b1, 32'h0000_0100, 32'hFFFF_FFFF, 4'hF, 32'h0};
    vecs[6]  = '{1'b0, 32'h0000_0100, 32'h0,         4'hF, 32'h0};
    vecs[7]  = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'h0};
    vecs[8]  = '{1'b0, 32'h0000_000B, 32'h0,         4'h0, 32'h1234_5678};
    vecs[9]  = '{1'b1, 32'h0000_0010, 32'h9999_9999, 4'h0, 32'h0};
    vecs[10] = '{1'b0, 32'h0000_0010, 32'h0,         4'hF, 32'h0};
    vecs[11] = '{1'b1, 32'h0000_00FC, 32'hCAFE_F00D, 4'hF, 32'h0};
    vecs[12] = '{1'b0, 32'h0000_00FF, 32'h0,         4'h0, 32'hCAFE_F00D};
    vecs[13] = '{1'b1, 32'h8000_0008, 32'hFFFF_FFFF, 4'hF, 32'h0};
    vecs[14] = '{1'b0, 32'h8000_0008, 32'h0,         4'hF, 32'h0};
    vecs[15] = '{1'b0, 32'h0000_0008, 32'h0,         4'hF, 32'h1234_5678};

    // Reset state.
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < NDUT; k++) begin
      chk($sformatf("reset dut%0d ack", k), {31'h0, ack_w[k]}, 32'h0);
      chk($sformatf("reset dut%0d dat_o", k), dato_w[k], 32'h0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed table.
    for (int i = 0; i < 16; i++) begin
      do_txn(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, 1);
      check_txn($sformatf("vec%0d", i), vecs[i].we, vecs[i].exp, 1, 3'b111);
      if (vecs[i].we) model_write(vecs[i].adr, vecs[i].dat, vecs[i].sel);
    end

    // Strobe held continuously: recapture only after ACK_O has fallen.
    do_txn(1'b0, 32'h0000_0008, 32'h0, 4'hF, 8);
    check_txn("held_stb", 1'b0, model_read(32'h8), 8, 3'b111);

    // Reset in the middle of a pending write.
    @(negedge clk);
    we = 1'b1; adr = 32'h10; dat = 32'hDEAD_BEEF; sel = 4'hF; stb = 1'b1; cyc = 1'b1;
    @(negedge clk);
    rst_n = 1'b0; stb = 1'b0; cyc = 1'b0;
    #1;
    for (int k = 0; k < NDUT; k++) chk($sformatf("midrst dut%0d ack", k), {31'h0, ack_w[k]}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    quiet = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      for (int k = 0; k < NDUT; k++) if (ack_w[k]) quiet++;
    end
    chk("midrst late_acks", quiet, 0);
    do_txn(1'b0, 32'h10, 32'h0, 4'hF, 1);
    check_txn("midrst rd10", 1'b0, 32'h0, 1, 3'b111);
    do_txn(1'b0, 32'h08, 32'h0, 4'hF, 1);
    check_txn("midrst rd08", 1'b0, 32'h0, 1, 3'b111);

    // Extra strobes during WAIT and during the ACK cycle of the WAIT_CYCLES=1 copy.
    @(negedge clk);
    we = 1'b1; adr = 32'h20; dat = 32'h1111_1111; sel = 4'hF; stb = 1'b1; cyc = 1'b1;
    cnt1 = 0; cyc1 = -1;
    for (int c = 0; c < WINDOW; c++) begin
      @(posedge clk); #1;
      if (ack_w[1]) begin
        if (cnt1 == 0) cyc1 = c;
        cnt1++;
      end
      if (c == 0) begin adr = 32'h24; dat = 32'h2222_2222; end
      if (c == 1) begin stb = 1'b0; cyc = 1'b0; end
      if (c == 2) begin stb = 1'b1; cyc = 1'b1; end
      if (c == 3) begin stb = 1'b0; cyc = 1'b0; end
    end
    txn_id++;
    $display("txn %0d busy_ignore dut1 acks=%0d at=%0d", txn_id, cnt1, cyc1);
    chk("busy dut1 ack_count", cnt1, 1);
    chk("busy dut1 ack_latency", cyc1, 2);
    model_write(32'h20, 32'h1111_1111, 4'hF);
    do_txn(1'b0, 32'h24, 32'h0, 4'hF, 1);
    check_txn("busy rd24", 1'b0, 32'h0, 1, 3'b110);
    do_txn(1'b0, 32'h20, 32'h0, 4'hF, 1);
    check_txn("busy rd20", 1'b0, 32'h1111_1111, 1, 3'b111);
    apply_reset();

    // Random traffic against the memory model.
    for (int i = 0; i < 1000; i++) begin
      r_we  = 1'($urandom);
      r_adr = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 255));
      r_dat = $urandom;
      r_sel = 4'($urandom);
      r_exp = model_read(r_adr);
      do_txn(r_we, r_adr, r_dat, r_sel, 1);
      check_txn($sformatf("rnd%0d adr=%h", i, r_adr), r_we, r_exp, 1, 3'b111);
      if (r_we) model_write(r_adr, r_dat, r_sel);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
